// File: rtl/uart_pkg.sv
// Shared types and constants for the IOBUS UART transmitter.
//   tx_state_t : serialiser state encoding (IDLE, START, DATA, STOP)
//   STAT_*     : bit positions inside the status word returned on RDATA
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam int STAT_BUSY = 0;
  localparam int STAT_FULL = 1;
  localparam int STAT_OVF  = 2;

  // Assemble the 32-bit status word from its three flags.
  function automatic logic [31:0] pack_status(input logic ovf, input logic full, input logic busy);
    logic [31:0] w_word;
    w_word            = 32'h0000_0000;
    w_word[STAT_OVF]  = ovf;
    w_word[STAT_FULL] = full;
    w_word[STAT_BUSY] = busy;
    return w_word;
  endfunction

endpackage

// File: rtl/byte_fifo.sv
// Synchronous byte FIFO with show-ahead read data.
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_push, i_din  : write request and byte; ignored when full unless a pop
//                    happens in the same cycle
//   i_pop          : read request; ignored when empty
//   o_dout         : byte at the head of the FIFO (valid when !o_empty)
//   o_full, o_empty: occupancy flags derived from the registered count
module byte_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_push,
  input  logic       i_pop,
  input  logic [7:0] i_din,
  output logic [7:0] o_dout,
  output logic       o_full,
  output logic       o_empty
);
  import uart_pkg::*;

  localparam int AW = $clog2(DEPTH);

  logic [7:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_do_pop;
  logic          w_do_push;

  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == (AW+1)'(0));
  assign o_dout  = r_mem[r_rd_ptr];

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  // Storage write; contents need no reset since the count gates every read.
  always_ff @(posedge i_clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_din;
    end
  end

  // Pointers wrap modulo DEPTH (power of two); count tracks occupancy.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= AW'(0);
      r_rd_ptr <= AW'(0);
      r_count  <= (AW+1)'(0);
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end else begin
        r_wr_ptr <= r_wr_ptr;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end else begin
        r_rd_ptr <= r_rd_ptr;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/iobus_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the OTTER IOBUS.
// Ports:
//   CLK, RST_N  : system clock, asynchronous active-low reset
//   IOBUS_ADDR  : CPU bus address
//   IOBUS_OUT   : CPU write data (only [7:0] is used for TX bytes)
//   IOBUS_WR    : one-cycle store strobe
//   RDATA       : status word when IOBUS_ADDR == STAT_AD, otherwise zero
//   TX          : registered serial output, idle high
// Stores to DATA_AD queue a byte; stores to STAT_AD clear the sticky overflow.
module iobus_uart_tx #(
  parameter int          CLK_PER_BIT = 434,
  parameter int          FIFO_DEPTH  = 4,
  parameter logic [31:0] DATA_AD     = 32'h1100_0060,
  parameter logic [31:0] STAT_AD     = 32'h1100_0064
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [31:0] IOBUS_ADDR,
  input  logic [31:0] IOBUS_OUT,
  input  logic        IOBUS_WR,
  output logic [31:0] RDATA,
  output logic        TX
);
  import uart_pkg::*;

  localparam int BW = $clog2(CLK_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLK_PER_BIT - 1);

  tx_state_t     r_state;
  tx_state_t     w_state_nxt;
  logic [BW-1:0] r_baud;
  logic [BW-1:0] w_baud_nxt;
  logic [2:0]    r_bit_idx;
  logic [2:0]    w_bit_nxt;
  logic [7:0]    r_shift;
  logic [7:0]    w_shift_nxt;
  logic          r_tx;
  logic          w_tx_nxt;
  logic          r_ovf;

  logic          w_data_wr;
  logic          w_stat_wr;
  logic          w_pop;
  logic          w_full;
  logic          w_empty;
  logic [7:0]    w_fifo_dout;
  logic          w_busy;
  logic          w_baud_last;
  logic          w_unused_upper;

  assign w_data_wr      = IOBUS_WR && (IOBUS_ADDR == DATA_AD);
  assign w_stat_wr      = IOBUS_WR && (IOBUS_ADDR == STAT_AD);
  assign w_busy         = (r_state != IDLE) || !w_empty;
  assign w_baud_last    = (r_baud == BAUD_LAST);
  assign w_unused_upper = ^IOBUS_OUT[31:8];
  assign TX             = r_tx;

  byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (CLK),
    .i_rst_n (RST_N),
    .i_push  (w_data_wr),
    .i_pop   (w_pop),
    .i_din   (IOBUS_OUT[7:0]),
    .o_dout  (w_fifo_dout),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Status read port merged into the wrapper's IOBUS input mux.
  always_comb begin
    RDATA = 32'h0000_0000;
    if (IOBUS_ADDR == STAT_AD) begin
      RDATA = pack_status(r_ovf, w_full, w_busy);
    end else begin
      RDATA = 32'h0000_0000;
    end
  end

  // Sticky overflow: a byte lost to a full FIFO that is not draining this cycle.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_ovf <= 1'b0;
    end else if (w_stat_wr) begin
      r_ovf <= 1'b0;
    end else if (w_data_wr && w_full && !w_pop) begin
      r_ovf <= 1'b1;
    end else begin
      r_ovf <= r_ovf;
    end
  end

  // Serialiser state, baud timing, bit index, shift register and TX register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state   <= IDLE;
      r_baud    <= BW'(0);
      r_bit_idx <= 3'd0;
      r_shift   <= 8'h00;
      r_tx      <= 1'b1;
    end else begin
      r_state   <= w_state_nxt;
      r_baud    <= w_baud_nxt;
      r_bit_idx <= w_bit_nxt;
      r_shift   <= w_shift_nxt;
      r_tx      <= w_tx_nxt;
    end
  end

  // Next-state logic. TX is registered from the current state, so the line
  // lags the state by one cycle; the single IDLE cycle between frames is the
  // cycle in which the next byte is popped.
  always_comb begin
    w_state_nxt = r_state;
    w_baud_nxt  = r_baud;
    w_bit_nxt   = r_bit_idx;
    w_shift_nxt = r_shift;
    w_tx_nxt    = 1'b1;
    w_pop       = 1'b0;
    case (r_state)
      IDLE: begin
        w_tx_nxt = 1'b1;
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_shift_nxt = w_fifo_dout;
          w_baud_nxt  = BW'(0);
          w_state_nxt = START;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      START: begin
        w_tx_nxt = 1'b0;
        if (w_baud_last) begin
          w_baud_nxt  = BW'(0);
          w_bit_nxt   = 3'd0;
          w_state_nxt = DATA;
        end else begin
          w_baud_nxt = r_baud + BW'(1);
        end
      end
      DATA: begin
        w_tx_nxt = r_shift[0];
        if (w_baud_last) begin
          w_baud_nxt  = BW'(0);
          w_shift_nxt = {1'b0, r_shift[7:1]};
          if (r_bit_idx == 3'd7) begin
            w_state_nxt = STOP;
          end else begin
            w_bit_nxt = r_bit_idx + 3'd1;
          end
        end else begin
          w_baud_nxt = r_baud + BW'(1);
        end
      end
      STOP: begin
        w_tx_nxt = 1'b1;
        if (w_baud_last) begin
          w_baud_nxt  = BW'(0);
          w_state_nxt = IDLE;
        end else begin
          w_baud_nxt = r_baud + BW'(1);
        end
      end
      default: begin
        w_tx_nxt    = 1'b1;
        w_baud_nxt  = BW'(0);
        w_state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_iobus_uart_tx.sv
// Bench for iobus_uart_tx: a transaction-level model predicts which bytes are
// accepted, when each frame starts and what the status word reads; a line
// monitor decodes TX and checks every frame against the expected queues.
module tb_iobus_uart_tx;

  localparam int          CPB     = 4;
  localparam int          DEPTH   = 4;
  localparam logic [31:0] DATA_AD = 32'h1100_0060;
  localparam logic [31:0] STAT_AD = 32'h1100_0064;
  localparam logic [31:0] OTHER_AD = 32'h1100_0020;

  logic        clk;
  logic        rst_n;
  logic [31:0] bus_addr;
  logic [31:0] bus_out;
  logic        bus_wr;
  logic [31:0] rdata;
  logic        tx;

  int n_cmp;
  int n_bad;

  // reference model state
  int         cyc;
  int         link_free;
  logic       ovf_m;
  logic [7:0] fifo_m[$];
  logic [7:0] exp_q[$];
  int         start_q[$];

  iobus_uart_tx #(
    .CLK_PER_BIT (CPB),
    .FIFO_DEPTH  (DEPTH),
    .DATA_AD     (DATA_AD),
    .STAT_AD     (STAT_AD)
  ) dut (
    .CLK        (clk),
    .RST_N      (rst_n),
    .IOBUS_ADDR (bus_addr),
    .IOBUS_OUT  (bus_out),
    .IOBUS_WR   (bus_wr),
    .RDATA      (rdata),
    .TX         (tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cycle %0d: got %h, required %h", name, cyc, act, exp);
    end
  endtask

  // Status predicted by the model: the link is occupied for 10*CPB cycles
  // after each pop, and bytes still waiting also count as busy.
  function automatic logic [31:0] model_stat();
    logic busy;
    logic full;
    busy = (cyc < link_free - 1) || (fifo_m.size() > 0);
    full = (fifo_m.size() == DEPTH);
    return {29'b0, ovf_m, full, busy};
  endfunction

  // Transaction model: one pop whenever the link is free and a byte waits;
  // a store is accepted if there is room before the edge or a pop frees it.
  always @(posedge clk) begin
    int  sz;
    bit  pop;
    cyc++;
    if (!rst_n) begin
      fifo_m.delete();
      exp_q.delete();
      start_q.delete();
      ovf_m     = 1'b0;
      link_free = 0;
    end else begin
      sz  = fifo_m.size();
      pop = (cyc >= link_free) && (sz > 0);
      if (pop) begin
        void'(fifo_m.pop_front());
        link_free = cyc + 10 * CPB + 1;
        start_q.push_back(cyc + 1);
      end
      if (bus_wr && bus_addr == DATA_AD) begin
        if (sz < DEPTH || pop) begin
          fifo_m.push_back(bus_out[7:0]);
          exp_q.push_back(bus_out[7:0]);
        end else begin
          ovf_m = 1'b1;
        end
      end else if (bus_wr && bus_addr == STAT_AD) begin
        ovf_m = 1'b0;
      end
    end
  end

  // Line monitor: samples each bit mid-cell and checks frames as they complete.
  initial begin
    bit         in_frame;
    int         fall;
    int         off;
    int         idx;
    logic [7:0] rx;
    in_frame = 1'b0;
    fall     = 0;
    rx       = 8'h00;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        in_frame = 1'b0;
      end else if (!in_frame) begin
        if (tx === 1'b0) begin
          in_frame = 1'b1;
          fall     = cyc;
          if (start_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_frame @cycle %0d: got start bit, required idle line", cyc);
          end else begin
            chk("start_edge", fall, start_q.pop_front());
          end
        end
      end else begin
        off = cyc - fall;
        if (off % CPB == CPB / 2) begin
          idx = off / CPB;
          if (idx == 0) begin
            chk("start_bit", {31'b0, tx}, 32'd0);
          end else if (idx <= 8) begin
            rx[idx-1] = tx;
          end else begin
            chk("stop_bit", {31'b0, tx}, 32'd1);
            if (exp_q.size() == 0) begin
              n_cmp++;
              n_bad++;
              $display("FAIL frame_byte @cycle %0d: got %h, required no frame", cyc, rx);
            end else begin
              chk("frame_byte", {24'b0, rx}, {24'b0, exp_q.pop_front()});
            end
            in_frame = 1'b0;
          end
        end
      end
    end
  end

  task automatic bus(input logic [31:0] a, input logic [31:0] d, input logic w);
    @(negedge clk);
    bus_addr = a;
    bus_out  = d;
    bus_wr   = w;
  endtask

  task automatic read_stat(input string name);
    bus(STAT_AD, 32'h0, 1'b0);
    #1;
    chk(name, rdata, model_stat());
  endtask

  task automatic drain();
    int t;
    t = 0;
    bus(32'h0, 32'h0, 1'b0);
    while ((exp_q.size() > 0 || model_stat() != {29'b0, ovf_m, 2'b00}) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    n_cmp++;
    if (t >= 3000) begin
      n_bad++;
      $display("FAIL drain_timeout @cycle %0d: got %0d frames outstanding, required 0", cyc, exp_q.size());
    end
  endtask

  initial begin
    int t;
    n_cmp     = 0;
    n_bad     = 0;
    cyc       = 0;
    link_free = 0;
    ovf_m     = 1'b0;
    rst_n     = 1'b0;
    bus_addr  = 32'h0;
    bus_out   = 32'h0;
    bus_wr    = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // reset state
    @(negedge clk);
    #1;
    chk("reset_tx", {31'b0, tx}, 32'd1);
    read_stat("reset_stat");
    chk("reset_stat_zero", rdata, 32'h0);

    // single byte, busy during the frame
    bus(DATA_AD, 32'h0000_00A5, 1'b1);
    bus(32'h0, 32'h0, 1'b0);
    repeat (10) @(negedge clk);
    read_stat("stat_busy_a5");
    drain();
    read_stat("stat_idle_a5");

    // back-to-back frames
    bus(DATA_AD, 32'h01, 1'b1);
    bus(DATA_AD, 32'h02, 1'b1);
    bus(DATA_AD, 32'h03, 1'b1);
    drain();

    // overflow with six consecutive stores, then clear
    for (int i = 0; i < 6; i++) begin
      bus(DATA_AD, 32'h40 + i, 1'b1);
    end
    read_stat("stat_overflow");
    bus(STAT_AD, 32'h0, 1'b1);
    read_stat("stat_ovf_cleared");
    drain();

    // upper data bits ignored; foreign address neither pushes nor reads back
    bus(DATA_AD, 32'h1234_55FF, 1'b1);
    bus(OTHER_AD, 32'h0000_0077, 1'b1);
    #1;
    chk("other_addr_rdata", rdata, 32'h0);
    drain();

    // asynchronous reset in the middle of a data bit
    bus(DATA_AD, 32'h00, 1'b1);
    bus(32'h0, 32'h0, 1'b0);
    t = 0;
    while (tx !== 1'b0 && t < 50) begin
      @(negedge clk);
      t++;
    end
    repeat (2 * CPB + 1) @(negedge clk);
    chk("tx_low_mid_data", {31'b0, tx}, 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("tx_async_reset", {31'b0, tx}, 32'd1);
    bus_addr = STAT_AD;
    #1;
    chk("stat_in_reset", rdata, 32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (100) @(negedge clk);
    #1;
    chk("tx_idle_after_reset", {31'b0, tx}, 32'd1);
    read_stat("stat_after_reset");

    // full FIFO with a store landing on the same edge as the IDLE pop
    for (int i = 0; i < 5; i++) begin
      bus(DATA_AD, 32'h80 + i, 1'b1);
    end
    bus(32'h0, 32'h0, 1'b0);
    read_stat("stat_full");
    t = 0;
    while (cyc != link_free - 1 && t < 200) begin
      @(negedge clk);
      t++;
    end
    bus(DATA_AD, 32'h0000_00C3, 1'b1);
    read_stat("stat_push_on_pop");
    drain();

    // randomized traffic
    for (int i = 0; i < 60; i++) begin
      int sel;
      sel = $urandom_range(0, 9);
      if (sel < 6) begin
        bus(DATA_AD, $urandom, 1'b1);
      end else if (sel == 6) begin
        bus(STAT_AD, $urandom, 1'b1);
      end else if (sel == 7) begin
        bus(OTHER_AD, $urandom, 1'b1);
        #1;
        chk("rand_other_rdata", rdata, 32'h0);
      end else if (sel == 8) begin
        read_stat("rand_stat");
      end else begin
        bus(32'h0, 32'h0, 1'b0);
        repeat ($urandom_range(0, 40)) @(negedge clk);
      end
    end
    drain();
    read_stat("final_stat");
    chk("final_start_q", start_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Hard stop in case something stalls beyond every bounded wait.
  initial begin
    #2_000_000;
    $display("FAIL watchdog @cycle %0d: got no completion, required finish", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
